// File: rtl/dsm_pkg.sv
// Shared widths, coefficient select encodings and sequencer state type
// for the delta-sigma sample sequencer slice.
package dsm_pkg;

    localparam int DW = 36;
    localparam int CW = 18;
    localparam int IW = 16;

    localparam logic [1:0] SEL_A = 2'd0;
    localparam logic [1:0] SEL_B = 2'd1;
    localparam logic [1:0] SEL_G = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [DW-1:0] sext_sample(input logic [IW-1:0] s);
        return {{(DW-IW){s[IW-1]}}, s};
    endfunction

endpackage

// File: rtl/coef_bank.sv
// Double-buffered coefficient store: cfg writes land in the shadow table,
// the whole shadow table is copied to the active table on copy_en.
module coef_bank
    import dsm_pkg::*;
#(
    parameter int NSTAGE = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_we,
    input  logic [3:0]    cfg_addr,
    input  logic [CW-1:0] cfg_wdata,
    input  logic          copy_en,
    input  logic          rd_en,
    input  logic [1:0]    rd_stage,
    output logic [CW-1:0] coef_a,
    output logic [CW-1:0] coef_b,
    output logic [CW-1:0] coef_g
);

    logic [CW-1:0] sh_a  [NSTAGE];
    logic [CW-1:0] sh_b  [NSTAGE];
    logic [CW-1:0] sh_g  [NSTAGE];
    logic [CW-1:0] act_a [NSTAGE];
    logic [CW-1:0] act_b [NSTAGE];
    logic [CW-1:0] act_g [NSTAGE];

    logic [1:0] wr_stage;
    logic [1:0] wr_sel;

    assign wr_stage = cfg_addr[3:2];
    assign wr_sel   = cfg_addr[1:0];

    // Stages beyond NSTAGE never match the loop index, so those writes fall away.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned s = 0; s < NSTAGE; s++) begin
                sh_a[s]  <= '0;
                sh_b[s]  <= '0;
                sh_g[s]  <= '0;
                act_a[s] <= '0;
                act_b[s] <= '0;
                act_g[s] <= '0;
            end
        end else begin
            for (int unsigned s = 0; s < NSTAGE; s++) begin
                if (copy_en) begin
                    act_a[s] <= sh_a[s];
                    act_b[s] <= sh_b[s];
                    act_g[s] <= sh_g[s];
                end
                if (cfg_we && (wr_stage == 2'(s))) begin
                    case (wr_sel)
                        SEL_A:   sh_a[s] <= cfg_wdata;
                        SEL_B:   sh_b[s] <= cfg_wdata;
                        SEL_G:   sh_g[s] <= cfg_wdata;
                        default: ;
                    endcase
                end
            end
        end
    end

    always_comb begin
        coef_a = '0;
        coef_b = '0;
        coef_g = '0;
        for (int unsigned s = 0; s < NSTAGE; s++) begin
            if (rd_en && (rd_stage == 2'(s))) begin
                coef_a = act_a[s];
                coef_b = act_b[s];
                coef_g = act_g[s];
            end
        end
    end

endmodule

// File: rtl/dsm_seq.sv
// Sample-rate sequencer: period counter, sample capture, underrun counting
// and the per-period walk over the shared fac stages.
module dsm_seq
    import dsm_pkg::*;
#(
    parameter int DIV    = 64,
    parameter int NSTAGE = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          cfg_we,
    input  logic [3:0]    cfg_addr,
    input  logic [CW-1:0] cfg_wdata,
    output logic          fs_enb,
    output logic [DW-1:0] smp_out,
    output logic          stg_en,
    output logic [1:0]    stg_sel,
    output logic [CW-1:0] coef_a,
    output logic [CW-1:0] coef_b,
    output logic [CW-1:0] coef_g,
    output logic          busy,
    output logic [7:0]    underrun_cnt
);

    localparam int CNTW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DIV - 1);

    generate
        if ((NSTAGE < 1) || (NSTAGE > 4) || (DIV < NSTAGE + 2)) begin : g_bad_params
            $error("dsm_seq: requires 1 <= NSTAGE <= 4 and DIV >= NSTAGE+2");
        end
    endgenerate

    logic [CNTW-1:0] cnt;
    logic [DW-1:0]   smp_q;
    logic [7:0]      und_q;
    state_t          state, state_nx;
    logic [1:0]      sel_q, sel_nx;

    // Strobes are gated by rst so nothing fires while reset is held.
    assign fs_enb   = !rst && (cnt == CNT_LAST);
    assign in_ready = fs_enb;
    assign stg_en   = !rst && (state == RUN);
    assign busy     = !rst && ((state == RUN) || (state == DONE));
    assign stg_sel  = sel_q;
    assign smp_out  = smp_q;
    assign underrun_cnt = und_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            smp_q <= '0;
            und_q <= '0;
        end else if (fs_enb) begin
            if (in_valid) begin
                smp_q <= sext_sample(in_data);
            end else if (und_q != 8'hFF) begin
                und_q <= und_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sel_q <= '0;
        end else begin
            state <= state_nx;
            sel_q <= sel_nx;
        end
    end

    always_comb begin
        state_nx = state;
        sel_nx   = sel_q;
        case (state)
            IDLE: begin
                if (fs_enb) begin
                    state_nx = RUN;
                    sel_nx   = '0;
                end
            end
            RUN: begin
                if (sel_q == 2'(NSTAGE - 1)) begin
                    state_nx = DONE;
                end else begin
                    sel_nx = sel_q + 2'd1;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    coef_bank #(
        .NSTAGE(NSTAGE)
    ) u_coef_bank (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .copy_en   (fs_enb),
        .rd_en     (stg_en),
        .rd_stage  (sel_q),
        .coef_a    (coef_a),
        .coef_b    (coef_b),
        .coef_g    (coef_g)
    );

endmodule

// File: tb/tb_dsm_seq.sv
// Bench for dsm_seq at DIV=8, NSTAGE=3 against a period-arithmetic reference model.
module tb_dsm_seq;

    localparam int DIV    = 8;
    localparam int NSTAGE = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [17:0] cfg_wdata;
    logic        fs_enb;
    logic [35:0] smp_out;
    logic        stg_en;
    logic [1:0]  stg_sel;
    logic [17:0] coef_a, coef_b, coef_g;
    logic        busy;
    logic [7:0]  underrun_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model: t counts cycles since reset release.
    int          t = 0;
    logic [35:0] m_smp = '0;
    int          m_under = 0;
    logic [17:0] m_sh  [4][3];
    logic [17:0] m_act [4][3];

    always #5 clk = ~clk;

    dsm_seq #(
        .DIV    (DIV),
        .NSTAGE (NSTAGE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_wdata    (cfg_wdata),
        .fs_enb       (fs_enb),
        .smp_out      (smp_out),
        .stg_en       (stg_en),
        .stg_sel      (stg_sel),
        .coef_a       (coef_a),
        .coef_b       (coef_b),
        .coef_g       (coef_g),
        .busy         (busy),
        .underrun_cnt (underrun_cnt)
    );

    function automatic logic e_fs();
        return !rst && (t % DIV == DIV - 1);
    endfunction

    function automatic logic e_en();
        return !rst && (t >= DIV) && (t % DIV < NSTAGE);
    endfunction

    function automatic logic e_busy();
        return !rst && (t >= DIV) && (t % DIV <= NSTAGE);
    endfunction

    function automatic logic [17:0] e_coef(input int k);
        return e_en() ? m_act[t % DIV][k] : 18'd0;
    endfunction

    task automatic model_clear();
        for (int s = 0; s < 4; s++)
            for (int k = 0; k < 3; k++) begin
                m_sh[s][k]  = '0;
                m_act[s][k] = '0;
            end
    endtask

    task automatic adv();
        logic fs;
        fs = e_fs();
        if (rst) begin
            t = 0;
            m_smp = '0;
            m_under = 0;
            model_clear();
        end else begin
            if (fs) begin
                m_act = m_sh;
                if (in_valid) m_smp = 36'($signed(in_data));
                else if (m_under < 255) m_under++;
            end
            if (cfg_we && cfg_addr[1:0] != 2'd3 && int'(cfg_addr[3:2]) < NSTAGE)
                m_sh[cfg_addr[3:2]][cfg_addr[1:0]] = cfg_wdata;
            t++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic goto_phase(input int ph);
        int unsigned n;
        n = 0;
        do begin
            adv();
            n++;
        end while (!((t >= DIV) && (t % DIV == ph)) && n < 4 * DIV);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        adv();
        adv();
        checks++;
        if ({fs_enb, in_ready, stg_en, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_strobes: got %b want 0000", {fs_enb, in_ready, stg_en, busy});
        end
        checks++;
        if (smp_out !== 36'd0) begin
            errors++;
            $display("FAIL reset_smp: got %h want 0", smp_out);
        end
        checks++;
        if (underrun_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_underrun: got %0d want 0", underrun_cnt);
        end
        rst = 1'b0;
        adv();
        checks++;
        if ({fs_enb, in_ready, stg_en, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL post_reset_strobes: got %b want 0000", {fs_enb, in_ready, stg_en, busy});
        end
        for (int i = 0; i < 3 * DIV; i++) begin
            checks++;
            if (fs_enb !== e_fs() || in_ready !== e_fs()) begin
                errors++;
                $display("FAIL idle_fs t=%0d: got fs=%b rdy=%b want %b", t, fs_enb, in_ready, e_fs());
            end
            checks++;
            if (underrun_cnt !== 8'(m_under) || smp_out !== 36'd0) begin
                errors++;
                $display("FAIL idle_cnt t=%0d: got und=%0d smp=%h want und=%0d smp=0", t, underrun_cnt, smp_out, m_under);
            end
            adv();
        end
        checks++;
        if (underrun_cnt !== 8'd3) begin
            errors++;
            $display("FAIL idle_underrun3: got %0d want 3", underrun_cnt);
        end
    endtask

    task automatic test_sample();
        in_data  = 16'h8001;
        in_valid = 1'b1;
        goto_phase(DIV - 1);
        adv();
        checks++;
        if (smp_out !== 36'hFFFFF8001) begin
            errors++;
            $display("FAIL sample_sext: got %h want FFFFF8001", smp_out);
        end
        for (int i = 0; i < DIV; i++) begin
            checks++;
            if (stg_en !== e_en() || busy !== e_busy() || (e_en() && stg_sel !== 2'(t % DIV))) begin
                errors++;
                $display("FAIL sample_seq ph=%0d: got en=%b busy=%b sel=%0d want en=%b busy=%b sel=%0d",
                         t % DIV, stg_en, busy, stg_sel, e_en(), e_busy(), t % DIV);
            end
            adv();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_coef_mid();
        goto_phase(0);
        cfg_we = 1'b1; cfg_addr = 4'h5; cfg_wdata = 18'h01234;
        adv();
        cfg_we = 1'b0;
        checks++;
        if (stg_sel !== 2'd1 || coef_b !== 18'd0 || coef_b !== e_coef(1)) begin
            errors++;
            $display("FAIL coef_mid_now: got sel=%0d b=%h want sel=1 b=0", stg_sel, coef_b);
        end
        goto_phase(1);
        checks++;
        if (coef_b !== 18'h01234 || coef_a !== 18'd0 || coef_g !== 18'd0) begin
            errors++;
            $display("FAIL coef_mid_next: got a=%h b=%h g=%h want a=0 b=01234 g=0", coef_a, coef_b, coef_g);
        end
    endtask

    task automatic test_coef_fs();
        goto_phase(DIV - 1);
        checks++;
        if (fs_enb !== 1'b1) begin
            errors++;
            $display("FAIL coef_fs_strobe: got %b want 1", fs_enb);
        end
        cfg_we = 1'b1; cfg_addr = 4'h6; cfg_wdata = 18'h2AAAA;
        adv();
        cfg_we = 1'b0;
        goto_phase(1);
        checks++;
        if (coef_g !== 18'd0) begin
            errors++;
            $display("FAIL coef_fs_absent: got g=%h want 0", coef_g);
        end
        goto_phase(1);
        checks++;
        if (coef_g !== 18'h2AAAA) begin
            errors++;
            $display("FAIL coef_fs_present: got g=%h want 2AAAA", coef_g);
        end
    endtask

    task automatic test_ignored();
        cfg_we = 1'b1; cfg_addr = 4'h3; cfg_wdata = 18'($urandom) | 18'h1;
        adv();
        cfg_addr = 4'hC; cfg_wdata = 18'($urandom) | 18'h1;
        adv();
        cfg_we = 1'b0;
        for (int i = 0; i < 3 * DIV; i++) begin
            checks++;
            if (coef_a !== e_coef(0) || coef_b !== e_coef(1) || coef_g !== e_coef(2)) begin
                errors++;
                $display("FAIL ignored_coef t=%0d: got %h/%h/%h want %h/%h/%h",
                         t, coef_a, coef_b, coef_g, e_coef(0), e_coef(1), e_coef(2));
            end
            adv();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom % 4) != 0;
            in_data   = 16'($urandom);
            cfg_we    = ($urandom % 5) == 0;
            cfg_addr  = 4'($urandom);
            cfg_wdata = 18'($urandom);
            checks++;
            if (fs_enb !== e_fs() || in_ready !== e_fs() || stg_en !== e_en() || busy !== e_busy()) begin
                errors++;
                $display("FAIL rand_ctrl t=%0d: got fs=%b rdy=%b en=%b busy=%b want fs=%b en=%b busy=%b",
                         t, fs_enb, in_ready, stg_en, busy, e_fs(), e_en(), e_busy());
            end
            checks++;
            if (smp_out !== m_smp || underrun_cnt !== 8'(m_under)) begin
                errors++;
                $display("FAIL rand_data t=%0d: got smp=%h und=%0d want smp=%h und=%0d",
                         t, smp_out, underrun_cnt, m_smp, m_under);
            end
            checks++;
            if ((e_en() && stg_sel !== 2'(t % DIV)) ||
                coef_a !== e_coef(0) || coef_b !== e_coef(1) || coef_g !== e_coef(2)) begin
                errors++;
                $display("FAIL rand_coef t=%0d: got sel=%0d %h/%h/%h want %h/%h/%h",
                         t, stg_sel, coef_a, coef_b, coef_g, e_coef(0), e_coef(1), e_coef(2));
            end
            adv();
        end
        cfg_we = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_rst_mid();
        goto_phase(1);
        checks++;
        if (stg_en !== 1'b1 || stg_sel !== 2'd1) begin
            errors++;
            $display("FAIL rst_mid_pre: got en=%b sel=%0d want en=1 sel=1", stg_en, stg_sel);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({fs_enb, in_ready, stg_en, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL rst_mid_during: got %b want 0000", {fs_enb, in_ready, stg_en, busy});
        end
        adv();
        rst = 1'b0;
        checks++;
        if ({fs_enb, in_ready, stg_en, busy} !== 4'b0000 || stg_sel !== 2'd0 || smp_out !== 36'd0 ||
            underrun_cnt !== 8'd0 || {coef_a, coef_b, coef_g} !== 54'd0) begin
            errors++;
            $display("FAIL rst_mid_after: got strb=%b sel=%0d smp=%h und=%0d coef=%h want all 0",
                     {fs_enb, in_ready, stg_en, busy}, stg_sel, smp_out, underrun_cnt, {coef_a, coef_b, coef_g});
        end
        for (int i = 0; i < DIV + 2; i++) begin
            checks++;
            if (fs_enb !== (t == DIV - 1) || stg_en !== e_en() || busy !== e_busy()) begin
                errors++;
                $display("FAIL rst_mid_restart t=%0d: got fs=%b en=%b busy=%b want fs=%b en=%b busy=%b",
                         t, fs_enb, stg_en, busy, (t == DIV - 1), e_en(), e_busy());
            end
            adv();
        end
    endtask

    task automatic test_saturate();
        in_valid = 1'b0;
        for (int i = 0; i < 300 * DIV; i++) begin
            if (e_fs()) begin
                checks++;
                if (underrun_cnt !== 8'(m_under)) begin
                    errors++;
                    $display("FAIL sat_track t=%0d: got %0d want %0d", t, underrun_cnt, m_under);
                end
            end
            adv();
        end
        checks++;
        if (underrun_cnt !== 8'd255) begin
            errors++;
            $display("FAIL sat_final: got %0d want 255", underrun_cnt);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_data = '0; in_valid = 1'b0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        model_clear();
        test_reset();
        test_sample();
        test_coef_mid();
        test_coef_fs();
        test_ignored();
        test_random();
        test_rst_mid();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dsm_seq.md
DSM_SEQ -- requirements
Module: dsm_seq

Interface
REQ-001 Parameter DIV, default 64: clock cycles per modulator sample period; legal only when DIV >= NSTAGE+2, otherwise elaboration SHALL fail.
REQ-002 Parameter NSTAGE, default 3: number of shared fac stages sequenced per period, range 1..4.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port in_data  input  16  signed audio sample from the tone source.
REQ-006 Port in_valid  input  1  in_data valid.
REQ-007 Port in_ready  output  1  sample acceptance window.
REQ-008 Port cfg_we  input  1  coefficient write strobe.
REQ-009 Port cfg_addr  input  4  {stage[3:2], sel[1:0]}; sel 0=gain A, 1=gain B, 2=gain G.
REQ-010 Port cfg_wdata  input  18  signed coefficient.
REQ-011 Port fs_enb  output  1  one-cycle sample-rate strobe to the datapath.
REQ-012 Port smp_out  output  36  held sample, sign-extended.
REQ-013 Port stg_en, stg_sel  output  1, 2  shared-stage enable and index.
REQ-014 Port coef_a, coef_b, coef_g  output  18 each  active coefficients of stage stg_sel.
REQ-015 Port busy  output  1  high in RUN and DONE.
REQ-016 Port underrun_cnt  output  8  missed-sample counter.

Function
REQ-017 Period counter SHALL count 0..DIV-1 and wrap to 0; fs_enb SHALL be 1 exactly when counter == DIV-1.
REQ-018 in_ready SHALL equal fs_enb; a transfer occurs when in_valid && in_ready.
REQ-019 On transfer, smp_out SHALL take sign-extended in_data on the next cycle; otherwise smp_out holds.
REQ-020 fs_enb cycle without transfer SHALL increment underrun_cnt, saturating at 255.
REQ-021 FSM states IDLE, RUN, DONE; IDLE->RUN on fs_enb, stg_sel loaded 0.
REQ-022 In RUN, stg_en SHALL be 1 and stg_sel SHALL increment each cycle; RUN->DONE after the cycle with stg_sel == NSTAGE-1.
REQ-023 DONE SHALL last exactly one cycle, then IDLE; stg_en = 0 in IDLE and DONE.
REQ-024 First stg_en cycle SHALL be the cycle after fs_enb, coincident with the new smp_out.
REQ-025 coef_* SHALL be the active-table entry for stg_sel, combinational from registers; zero when stg_en = 0.
REQ-026 cfg writes SHALL land in a shadow table any cycle; shadow copied to active table on each fs_enb cycle.
REQ-027 Write coincident with fs_enb SHALL reach shadow but not that copy; visible from the following period.
REQ-028 Writes with sel == 3 or stage >= NSTAGE SHALL be ignored.
REQ-029 Active coefficients SHALL never change while busy = 1.

Reset
REQ-030 rst SHALL clear period counter, FSM to IDLE, smp_out, underrun_cnt, shadow and active tables to 0.
REQ-031 During and in the cycle after rst, fs_enb, in_ready, stg_en, busy SHALL be 0; rst mid-RUN aborts the sequence with no further stg_en.
REQ-032 After rst release, first fs_enb SHALL occur DIV cycles later.

Structure
REQ-033 Shared package dsm_pkg SHALL hold widths (DW=36, CW=18, IW=16), sel encodings, and FSM state type.
REQ-034 Sub-module coef_bank SHALL implement shadow/active tables, write decode and copy; all else in dsm_seq.

Verification (DIV=8, NSTAGE=3)
REQ-035 Reset release, in_valid=0 -> fs_enb at cycles 7,15,23; underrun_cnt 1,2,3; smp_out 0.
REQ-036 in_data=0x8001 held valid -> smp_out=0xFFFFF8001 after first fs_enb; stg_sel 0,1,2 with stg_en, busy 4 cycles, then IDLE.
REQ-037 Write addr 0x5 data 0x1234 mid-period -> coef_b=0 while stg_sel=1 this period, 0x1234 while stg_sel=1 next period.
REQ-038 Write coincident with fs_enb -> value absent next period, present in period after.
REQ-039 Writes to addr 0x3 and 0xC -> all coefficients unchanged.
REQ-040 rst asserted during stg_sel=1 -> stg_en low from next cycle, all outputs 0, next fs_enb 8 cycles after release; 300 missing samples -> underrun_cnt saturates at 255.
